rx_failover_ctrl: RTL and testbench

- Arbitrates between two redundant servo-to-logic decoder channels, primary A and backup B. Each channel supplies a decoded logic level plus its rx_problem flag.
- Selects the healthy source with hysteresis and debounces the selected level. Falls back to a fixed failsafe level when neither source is usable.
- Sits between the decoder instances and the autopilot mode logic, on the same 10 kHz tick clock.

---
 rtl/rx_pkg.sv | 18 +
 rtl/rx_failover_ctrl_if.sv | 22 ++
 rtl/rx_health_mon.sv | 54 +++++
 rtl/rx_failover_ctrl.sv | 126 ++++++++++++
 tb/tb_rx_failover_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the redundant-receiver failover path.
// Source encoding and default timing are also used by the servo decoder.
package rx_pkg;

    typedef enum logic [1:0] {
        SRC_A  = 2'd0,
        SRC_B  = 2'd1,
        SRC_FS = 2'd2
    } src_t;

    // Timing at the 10 kHz tick.
    localparam int   DEF_LOSS_HOLD    = 500;
    localparam int   DEF_RECOVER_HOLD = 2000;
    localparam int   DEF_LOG_CONFIRM  = 600;
    localparam logic DEF_FAILSAFE_LOG = 1'b0;
    localparam int   DEF_CNT_W        = 12;

endpackage

// File: rtl/rx_failover_ctrl_if.sv
// Channel inputs and arbitrated outputs of rx_failover_ctrl.
// The master side is the decoder/autopilot side; the slave side is the controller.
interface rx_failover_ctrl_if;
    logic       log_a;
    logic       prob_a;
    logic       log_b;
    logic       prob_b;
    logic       out_log;
    logic [1:0] src;
    logic       failsafe;
    logic [7:0] switch_cnt;

    modport master (
        output log_a, prob_a, log_b, prob_b,
        input  out_log, src, failsafe, switch_cnt
    );

    modport slave (
        input  log_a, prob_a, log_b, prob_b,
        output out_log, src, failsafe, switch_cnt
    );
endinterface

// File: rtl/rx_health_mon.sv
// Per-channel health monitor: run-length counters on rx_problem.
// These counters give the lost/ok hysteresis band.
module rx_health_mon #(
    parameter int LOSS_HOLD    = 500,
    parameter int RECOVER_HOLD = 2000,
    parameter int CNT_W        = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic prob,
    output logic lost,
    output logic ok
);
    localparam logic [CNT_W-1:0] LOSS_MAX = CNT_W'(LOSS_HOLD);
    localparam logic [CNT_W-1:0] GOOD_MAX = CNT_W'(RECOVER_HOLD);

    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;

    // Saturating counters; each one clears when the opposite condition is seen.
    always_comb begin
        bad_cnt_d  = bad_cnt_q;
        good_cnt_d = good_cnt_q;
        if (prob) begin
            good_cnt_d = {CNT_W{1'b0}};
            if (bad_cnt_q != LOSS_MAX) begin
                bad_cnt_d = bad_cnt_q + CNT_W'(1);
            end else begin
                bad_cnt_d = bad_cnt_q;
            end
        end else begin
            bad_cnt_d = {CNT_W{1'b0}};
            if (good_cnt_q != GOOD_MAX) begin
                good_cnt_d = good_cnt_q + CNT_W'(1);
            end else begin
                good_cnt_d = good_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_cnt_q  <= {CNT_W{1'b0}};
            good_cnt_q <= {CNT_W{1'b0}};
        end else begin
            bad_cnt_q  <= bad_cnt_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    assign lost = (bad_cnt_q == LOSS_MAX);
    assign ok   = (good_cnt_q == GOOD_MAX);
endmodule

// File: rtl/rx_failover_ctrl.sv
// Arbitrates primary/backup receiver channels with hysteresis, debounces the
// selected level and falls back to a fixed level when neither channel is usable.
module rx_failover_ctrl
    import rx_pkg::*;
#(
    parameter int   LOSS_HOLD    = DEF_LOSS_HOLD,
    parameter int   RECOVER_HOLD = DEF_RECOVER_HOLD,
    parameter int   LOG_CONFIRM  = DEF_LOG_CONFIRM,
    parameter logic FAILSAFE_LOG = DEF_FAILSAFE_LOG,
    parameter int   CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    rx_failover_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(LOG_CONFIRM - 1);

    logic lost_a_s, ok_a_s, lost_b_s, ok_b_s;
    logic sel_log_s, new_log_s;

    src_t             state_q, state_d;
    logic             out_log_q, out_log_d;
    logic             failsafe_q, failsafe_d;
    logic [7:0]       switch_cnt_q, switch_cnt_d;
    logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

    rx_health_mon #(.LOSS_HOLD(LOSS_HOLD), .RECOVER_HOLD(RECOVER_HOLD), .CNT_W(CNT_W)) u_mon_a (
        .clk(clk), .rst(rst), .prob(bus.prob_a), .lost(lost_a_s), .ok(ok_a_s)
    );

    rx_health_mon #(.LOSS_HOLD(LOSS_HOLD), .RECOVER_HOLD(RECOVER_HOLD), .CNT_W(CNT_W)) u_mon_b (
        .clk(clk), .rst(rst), .prob(bus.prob_b), .lost(lost_b_s), .ok(ok_b_s)
    );

    // Source selection; a channel that is neither lost nor ok keeps the current state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SRC_FS: begin
                if (ok_a_s) begin
                    state_d = SRC_A;
                end else if (ok_b_s) begin
                    state_d = SRC_B;
                end else begin
                    state_d = SRC_FS;
                end
            end
            SRC_A: begin
                if (lost_a_s) begin
                    if (ok_b_s) begin
                        state_d = SRC_B;
                    end else begin
                        state_d = SRC_FS;
                    end
                end else begin
                    state_d = SRC_A;
                end
            end
            SRC_B: begin
                if (ok_a_s) begin
                    state_d = SRC_A;
                end else if (lost_b_s) begin
                    state_d = SRC_FS;
                end else begin
                    state_d = SRC_B;
                end
            end
            default: state_d = SRC_FS;
        endcase
    end

    assign sel_log_s = (state_q == SRC_B) ? bus.log_b : bus.log_a;
    assign new_log_s = (state_d == SRC_B) ? bus.log_b : bus.log_a;

    // Output level: loaded directly on a switch, otherwise only after a confirmed change.
    always_comb begin
        out_log_d  = out_log_q;
        conf_cnt_d = conf_cnt_q;
        if (state_d == SRC_FS) begin
            out_log_d  = FAILSAFE_LOG;
            conf_cnt_d = {CNT_W{1'b0}};
        end else if (state_d != state_q) begin
            out_log_d  = new_log_s;
            conf_cnt_d = {CNT_W{1'b0}};
        end else if (sel_log_s == out_log_q) begin
            conf_cnt_d = {CNT_W{1'b0}};
        end else if (conf_cnt_q >= CONF_LAST) begin
            out_log_d  = sel_log_s;
            conf_cnt_d = {CNT_W{1'b0}};
        end else begin
            conf_cnt_d = conf_cnt_q + CNT_W'(1);
        end
    end

    // Switch counter saturates rather than wrapping.
    always_comb begin
        failsafe_d = (state_d == SRC_FS);
        if ((state_d != state_q) && (switch_cnt_q != 8'hFF)) begin
            switch_cnt_d = switch_cnt_q + 8'd1;
        end else begin
            switch_cnt_d = switch_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SRC_FS;
            out_log_q    <= FAILSAFE_LOG;
            failsafe_q   <= 1'b1;
            switch_cnt_q <= 8'd0;
            conf_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            out_log_q    <= out_log_d;
            failsafe_q   <= failsafe_d;
            switch_cnt_q <= switch_cnt_d;
            conf_cnt_q   <= conf_cnt_d;
        end
    end

    assign bus.src        = state_q;
    assign bus.out_log    = out_log_q;
    assign bus.failsafe   = failsafe_q;
    assign bus.switch_cnt = switch_cnt_q;
endmodule

// File: tb/tb_rx_failover_ctrl.sv
// Scoreboard bench for rx_failover_ctrl: directed scenarios plus random
// stimulus, checked against a run-length reference model.
module tb_rx_failover_ctrl;
    localparam int   LOSS    = 4;
    localparam int   RECOVER = 8;
    localparam int   LC      = 3;
    localparam logic FS_LOG  = 1'b0;

    typedef struct {
        logic [1:0] src;
        logic       out;
        logic       fs;
        logic [7:0] sw;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;
    exp_t exp_q[$];

    rx_failover_ctrl_if bus_if ();

    rx_failover_ctrl #(
        .LOSS_HOLD(LOSS), .RECOVER_HOLD(RECOVER), .LOG_CONFIRM(LC),
        .FAILSAFE_LOG(FS_LOG), .CNT_W(12)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Reference model state: run lengths of consecutive problem/clean cycles.
    int         run_bad_a, run_good_a, run_bad_b, run_good_b, diff_run;
    int         m_src;
    logic       m_out;
    int         m_sw;
    logic       la, pa, lb, pb;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r);
        bit   lost_a, ok_a, lost_b, ok_b;
        int   nsrc;
        logic sel;
        exp_t e;
        if (r) begin
            m_src = 2; m_out = FS_LOG; m_sw = 0; diff_run = 0;
            run_bad_a = 0; run_good_a = 0; run_bad_b = 0; run_good_b = 0;
        end else begin
            lost_a = run_bad_a >= LOSS;  ok_a = run_good_a >= RECOVER;
            lost_b = run_bad_b >= LOSS;  ok_b = run_good_b >= RECOVER;
            if (m_src == 2)      nsrc = ok_a ? 0 : (ok_b ? 1 : 2);
            else if (m_src == 0) nsrc = !lost_a ? 0 : (ok_b ? 1 : 2);
            else                 nsrc = ok_a ? 0 : (lost_b ? 2 : 1);
            if (nsrc == 2) begin
                m_out = FS_LOG; diff_run = 0;
            end else if (nsrc != m_src) begin
                m_out = (nsrc == 1) ? lb : la; diff_run = 0;
            end else begin
                sel = (nsrc == 1) ? lb : la;
                if (sel == m_out) diff_run = 0;
                else begin
                    diff_run++;
                    if (diff_run >= LC) begin m_out = sel; diff_run = 0; end
                end
            end
            if (nsrc != m_src && m_sw < 255) m_sw++;
            m_src = nsrc;
            if (pa) begin run_bad_a++; run_good_a = 0; end else begin run_good_a++; run_bad_a = 0; end
            if (pb) begin run_bad_b++; run_good_b = 0; end else begin run_good_b++; run_bad_b = 0; end
        end
        e.src = 2'(m_src); e.out = m_out; e.fs = (m_src == 2); e.sw = 8'(m_sw);
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs, let the edge happen, record what the model expects.
    task automatic cycle(input logic r);
        rst = r;
        bus_if.log_a = la; bus_if.prob_a = pa;
        bus_if.log_b = lb; bus_if.prob_b = pb;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("src", int'(bus_if.src), int'(e.src));
                chk("out_log", int'(bus_if.out_log), int'(e.out));
                chk("failsafe", int'(bus_if.failsafe), int'(e.fs));
                chk("switch_cnt", int'(bus_if.switch_cnt), int'(e.sw));
            end
        end
    end

    initial begin
        la = 1'b1; pa = 1'b0; lb = 1'b0; pb = 1'b1;
        cycle(1'b1); cycle(1'b1);
        chk("reset_src", int'(bus_if.src), 2);
        chk("reset_failsafe", int'(bus_if.failsafe), 1);

        // A recovers, B still bad.
        run(8);
        chk("pre_recover_src", int'(bus_if.src), 2);
        run(1);
        chk("recover_src", int'(bus_if.src), 0);
        chk("recover_out", int'(bus_if.out_log), 1);
        chk("recover_sw", int'(bus_if.switch_cnt), 1);

        // B healthy, then A lost -> B, then A back -> A.
        pb = 1'b0; run(10);
        pa = 1'b1; run(5);
        chk("to_b_src", int'(bus_if.src), 1);
        chk("to_b_out", int'(bus_if.out_log), 0);
        pa = 1'b0; run(9);
        chk("back_a_src", int'(bus_if.src), 0);

        // Debounce: short glitch filtered, sustained change accepted.
        la = 1'b0; run(2); la = 1'b1; run(3);
        chk("glitch_out", int'(bus_if.out_log), 1);
        la = 1'b0; run(2);
        chk("confirm_pending", int'(bus_if.out_log), 1);
        run(1);
        chk("confirm_out", int'(bus_if.out_log), 0);
        la = 1'b1; run(4);

        // Hysteresis with B lost, then real loss into failsafe.
        pb = 1'b1; run(6);
        pa = 1'b1; run(3); pa = 1'b0; run(2);
        chk("hyst_src", int'(bus_if.src), 0);
        pa = 1'b1; run(6);
        chk("fs_src", int'(bus_if.src), 2);
        chk("fs_flag", int'(bus_if.failsafe), 1);
        chk("fs_out", int'(bus_if.out_log), 0);

        // Alternating loss/recovery to saturate the switch counter.
        for (int k = 0; k < 150; k++) begin
            pa = 1'b0; run(9);
            pa = 1'b1; run(5);
        end
        chk("sw_saturate", int'(bus_if.switch_cnt), 255);

        // Reach B, reset mid-operation, re-entry needs a full clean window.
        pb = 1'b0; run(9);
        chk("pre_rst_src", int'(bus_if.src), 1);
        cycle(1'b1);
        chk("rst_src", int'(bus_if.src), 2);
        chk("rst_out", int'(bus_if.out_log), 0);
        chk("rst_sw", int'(bus_if.switch_cnt), 0);
        run(8);
        chk("rst_hold_src", int'(bus_if.src), 2);
        run(1);
        chk("rst_reentry_src", int'(bus_if.src), 1);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) pa = ~pa;
            if ($urandom_range(0, 11) == 0) pb = ~pb;
            if ($urandom_range(0, 3) == 0) la = ~la;
            if ($urandom_range(0, 3) == 0) lb = ~lb;
            cycle($urandom_range(0, 499) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
